if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_pc_sel.sv | 40 ++++
 rtl/if_stage.sv | 78 +++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared CPU constants and helpers for the fetch stage
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0180;
    localparam logic [31:0] NOP_INSTR           = 32'h0000_0000;  // SLL $0,$0,0
    localparam logic [31:0] PC_INCR             = 32'd4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR,
        SEL_TRAP
    } redirSel_e;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_pc_sel.sv
// rtl/if_stage_pc_sel.sv - fixed-priority redirect target mux (TRAP > JR > J > Z)
module pc_sel
    import if_stage_pkg::*;
(
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        TRAP,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    input  logic [31:0] trapVector,
    output logic        redirectReq,
    output logic [31:0] target
);

    redirSel_e sel;

    always_comb begin
        sel = SEL_NONE;
        if (TRAP)     sel = SEL_TRAP;
        else if (JR)  sel = SEL_JR;
        else if (J)   sel = SEL_JUMP;
        else if (Z)   sel = SEL_BRANCH;
    end

    always_comb begin
        target      = 32'h0000_0000;
        redirectReq = 1'b1;
        unique case (sel)
            SEL_TRAP:   target = trapVector;
            SEL_JR:     target = JrAddr;
            SEL_JUMP:   target = JumpAddr;
            SEL_BRANCH: target = BranchAddr;
            default:    redirectReq = 1'b0;
        endcase
        target = alignWord(target);
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, redirect handling, IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_IFWrite,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        TRAP,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Rdata,
    input  logic        IMem_Ready,
    output logic [31:0] Instruction_id,
    output logic [31:0] NextPC_id,
    output logic        Valid_id
);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] target;
    logic        redirectReq;
    logic        redirect;

    pc_sel pcSelInst (
        .Z           (Z),
        .J           (J),
        .JR          (JR),
        .TRAP        (TRAP),
        .BranchAddr  (BranchAddr),
        .JumpAddr    (JumpAddr),
        .JrAddr      (JrAddr),
        .trapVector  (TRAP_VECTOR),
        .redirectReq (redirectReq),
        .target      (target)
    );

    assign pcPlus4   = pc + PC_INCR;
    assign redirect  = PC_IFWrite & redirectReq;
    assign IMem_Addr = pc;

    // A redirect abandons the in-flight fetch, so IMem_Ready is only looked at otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= alignWord(RESET_PC);
            Instruction_id <= NOP_INSTR;
            NextPC_id      <= 32'h0000_0000;
            Valid_id       <= 1'b0;
        end else if (!PC_IFWrite) begin
            pc             <= pc;
            Instruction_id <= Instruction_id;
            NextPC_id      <= NextPC_id;
            Valid_id       <= Valid_id;
        end else if (redirect) begin
            pc             <= target;
            Instruction_id <= NOP_INSTR;
            NextPC_id      <= 32'h0000_0000;
            Valid_id       <= 1'b0;
        end else if (IMem_Ready) begin
            pc             <= pcPlus4;
            Instruction_id <= IMem_Rdata;
            NextPC_id      <= pcPlus4;
            Valid_id       <= 1'b1;
        end else begin
            Instruction_id <= NOP_INSTR;
            NextPC_id      <= 32'h0000_0000;
            Valid_id       <= 1'b0;
        end
    end

endmodule
